// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the PUF control interface (collector and StateMachine).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    VALID   = 2'd3
  } collector_state_t;

  // Width of the loop-select field; one spare bit so out-of-range indices are representable.
  function automatic int sel_bits(input int num_loops);
    return $clog2(num_loops - 1) + 1;
  endfunction

  localparam int NUM_LOOPS_DEFAULT = 4;
  localparam int SEL_BITS          = sel_bits(NUM_LOOPS_DEFAULT);

endpackage

// File: rtl/ro_edge_sync.sv
// Synchronises one asynchronous ring-oscillator bit into i_clk and emits a one-cycle rising-edge pulse.
// Latency: pulse appears SYNC_STAGES cycles after the input rises.
// Backpressure: none; the RO toggles freely and must stay below clk/4.
module ro_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_ro,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Metastability chain followed by a one-cycle delayed copy for edge detection.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ro};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/puf_response_collector.sv
// Counts edges of the selected RO loop, accumulates per-loop totals, and compares loop pairs into a response word.
// Latency: done rising edge -> response_valid in 2 cycles; RO edge -> counter after SYNC_STAGES+1 cycles.
// Backpressure: none; control pulses are accepted every cycle, start always wins over store/done.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int  NUM_LOOPS   = 4,
  parameter int  COUNT_BITS  = 16,
  parameter int  ACC_BITS    = 20,
  parameter int  SYNC_STAGES = 2,
  localparam int SEL_W       = sel_bits(NUM_LOOPS),
  localparam int RESP_W      = NUM_LOOPS / 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_LOOPS-1:0] i_ro_in,
  input  logic                 i_start,
  input  logic                 i_reset_puf,
  input  logic [SEL_W-1:0]     i_select_puf,
  input  logic                 i_enable_puf,
  input  logic                 i_store_response_puf,
  input  logic                 i_done,
  output logic [RESP_W-1:0]    o_response,
  output logic                 o_response_valid,
  output logic                 o_overflow
);

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [ACC_BITS-1:0]   ACC_MAX = '1;

  collector_state_t       r_state;
  collector_state_t       w_state_nxt;
  logic [NUM_LOOPS-1:0]   w_rise;
  logic                   w_edge;
  logic                   w_sel_ok;
  logic [ACC_BITS-1:0]    w_sel_acc;
  logic                   r_done_d;
  logic                   w_done_rise;
  logic                   w_count;
  logic                   w_cnt_sat;
  logic                   w_store_en;
  logic [ACC_BITS:0]      w_sum;
  logic                   w_acc_sat;
  logic [COUNT_BITS-1:0]  r_cnt;
  logic [ACC_BITS-1:0]    r_acc [NUM_LOOPS];
  logic [RESP_W-1:0]      w_cmp;
  logic [RESP_W-1:0]      r_response;
  logic                   r_valid;
  logic                   r_overflow;

  genvar g;
  generate
    for (g = 0; g < NUM_LOOPS; g++) begin : g_sync
      ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ro    (i_ro_in[g]),
        .o_rise  (w_rise[g])
      );
    end
  endgenerate

  // Route the addressed loop's edge pulse and accumulator; an out-of-range index selects nothing.
  always_comb begin
    w_sel_ok  = 1'b0;
    w_edge    = 1'b0;
    w_sel_acc = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (i_select_puf == SEL_W'(i)) begin
        w_sel_ok  = 1'b1;
        w_edge    = w_rise[i];
        w_sel_acc = r_acc[i];
      end
    end
  end

  assign w_done_rise = i_done & ~r_done_d;
  assign w_count     = i_enable_puf & w_edge & ~i_reset_puf & ~i_start;
  assign w_cnt_sat   = w_count & (r_cnt == CNT_MAX);
  assign w_store_en  = (r_state == COLLECT) & i_store_response_puf & ~i_start & w_sel_ok;
  assign w_sum       = {1'b0, w_sel_acc} + {{(ACC_BITS + 1 - COUNT_BITS){1'b0}}, r_cnt};
  assign w_acc_sat   = w_store_en & w_sum[ACC_BITS];

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a start request overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = IDLE;
      COLLECT: if (w_done_rise) w_state_nxt = COMPARE;
      COMPARE: w_state_nxt = VALID;
      VALID:   w_state_nxt = VALID;
      default: w_state_nxt = IDLE;
    endcase
    if (i_start) w_state_nxt = COLLECT;
  end

  // Delayed copy of done so a held level only triggers once.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_done_d <= 1'b0;
    else          r_done_d <= i_done;
  end

  // Evaluation counter: clear has priority over counting; saturates at its maximum.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_start || i_reset_puf) begin
      r_cnt <= '0;
    end else if (w_count && !w_cnt_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Per-loop accumulators: add the pre-increment counter value on store, saturating at full scale.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) r_acc[i] <= '0;
    end else if (i_start) begin
      for (int i = 0; i < NUM_LOOPS; i++) r_acc[i] <= '0;
    end else if (w_store_en) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        if (i_select_puf == SEL_W'(i)) r_acc[i] <= w_sum[ACC_BITS] ? ACC_MAX : w_sum[ACC_BITS-1:0];
      end
    end
  end

  // Sticky saturation flag, cleared only by a new run or reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                    r_overflow <= 1'b0;
    else if (i_start)                r_overflow <= 1'b0;
    else if (w_cnt_sat || w_acc_sat) r_overflow <= 1'b1;
  end

  // Comparator bank: strictly greater, so equal totals give 0.
  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < RESP_W; i++) w_cmp[i] = r_acc[2*i] > r_acc[2*i+1];
  end

  // Capture the response while in COMPARE and hold it, flagged valid, until the next run.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_response <= '0;
      r_valid    <= 1'b0;
    end else if (i_start) begin
      r_response <= '0;
      r_valid    <= 1'b0;
    end else if (r_state == COMPARE) begin
      r_response <= w_cmp;
      r_valid    <= 1'b1;
    end
  end

  assign o_response       = r_response;
  assign o_response_valid = r_valid;
  assign o_overflow       = r_overflow;

endmodule

// File: tb/tb_puf_response_collector.sv
// Bench for puf_response_collector: table-driven runs, hand-written corner sequences, randomized runs.
// A second instance with 4-bit counters shares all stimulus to exercise counter saturation.
// Expected values come from per-loop edge totals computed in the bench.
module tb_puf_response_collector;
  import puf_pkg::*;

  typedef struct packed {
    logic [3:0][7:0] cnt;
    logic [1:0]      resp;
    logic [1:0]      resp_sat;
    logic            ovf_sat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ro;
  logic       start, reset_puf, en, store, done;
  logic [2:0] sel;
  logic [1:0] resp, resp_s;
  logic       valid, valid_s, ovf, ovf_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  puf_response_collector dut (
    .i_clk(clk), .i_reset(rst_n), .i_ro_in(ro), .i_start(start), .i_reset_puf(reset_puf),
    .i_select_puf(sel), .i_enable_puf(en), .i_store_response_puf(store), .i_done(done),
    .o_response(resp), .o_response_valid(valid), .o_overflow(ovf)
  );

  puf_response_collector #(.COUNT_BITS(4)) dut_sat (
    .i_clk(clk), .i_reset(rst_n), .i_ro_in(ro), .i_start(start), .i_reset_puf(reset_puf),
    .i_select_puf(sel), .i_enable_puf(en), .i_store_response_puf(store), .i_done(done),
    .o_response(resp_s), .o_response_valid(valid_s), .o_overflow(ovf_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ro_edge(input int l);
    ro[l] = 1'b1;
    tick(4);
    ro[l] = 1'b0;
    tick(4);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic store_sel(input int s);
    sel   = 3'(s);
    store = 1'b1;
    tick(1);
    store = 1'b0;
  endtask

  // One evaluation of loop l: clear counter, junk edges while disabled, n counted edges, optional store.
  task automatic eval_loop(input int l, input int n, input int junk, input bit do_store);
    sel       = 3'(l);
    reset_puf = 1'b1;
    tick(1);
    reset_puf = 1'b0;
    repeat (junk) ro_edge(l);
    tick(4);
    en = 1'b1;
    repeat (n) ro_edge(l);
    tick(4);
    en = 1'b0;
    if (do_store) store_sel(l);
  endtask

  // Pulse done (optionally with a store) and check the 2-cycle latency and final outputs of both instances.
  task automatic finish_run(input string tag, input logic [1:0] er, input logic eo,
                            input logic [1:0] esr, input logic eso, input bit with_store);
    done  = 1'b1;
    store = with_store;
    tick(1);
    done  = 1'b0;
    store = 1'b0;
    chk({tag, ".valid_after1"}, 32'(valid), 32'(0));
    tick(1);
    chk({tag, ".valid_after2"}, 32'(valid), 32'(1));
    chk({tag, ".resp"}, 32'(resp), 32'(er));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".sat_valid"}, 32'(valid_s), 32'(1));
    chk({tag, ".sat_resp"}, 32'(resp_s), 32'(esr));
    chk({tag, ".sat_ovf"}, 32'(ovf_s), 32'(eso));
  endtask

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3,
                              input logic [1:0] r, input logic [1:0] rs, input logic os);
    vec_t v;
    v.cnt[0]   = 8'(c0);
    v.cnt[1]   = 8'(c1);
    v.cnt[2]   = 8'(c2);
    v.cnt[3]   = 8'(c3);
    v.resp     = r;
    v.resp_sat = rs;
    v.ovf_sat  = os;
    return v;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vt[5];
    int         acc[4];
    int         accs[4];
    int         c;
    int         reps;
    logic       sov;
    logic [1:0] er, esr;

    // Each loop sees the same edge count in both of two repetitions.
    vt[0] = mk(10, 7, 5, 5, 2'b01, 2'b01, 1'b0);
    vt[1] = mk(3, 8, 9, 2, 2'b10, 2'b10, 1'b0);
    vt[2] = mk(0, 0, 0, 0, 2'b00, 2'b00, 1'b0);
    vt[3] = mk(18, 16, 6, 6, 2'b01, 2'b00, 1'b1);
    vt[4] = mk(4, 0, 4, 3, 2'b11, 2'b11, 1'b0);

    rst_n = 1'b0; ro = '0; start = 1'b0; reset_puf = 1'b0; en = 1'b0;
    store = 1'b0; done = 1'b0; sel = '0;
    tick(3);
    chk("reset.resp", 32'(resp), 32'(0));
    chk("reset.valid", 32'(valid), 32'(0));
    chk("reset.ovf", 32'(ovf), 32'(0));
    chk("reset.state", 32'(dut.r_state), 32'(IDLE));
    rst_n = 1'b1;
    tick(2);
    done = 1'b1; tick(1); done = 1'b0; tick(3);
    chk("idle_done_ignored", 32'(valid), 32'(0));

    // Table-driven full runs, two repetitions each; junk disabled edges in the second repetition.
    for (int v = 0; v < 5; v++) begin
      do_start();
      chk($sformatf("vec%0d.valid_cleared", v), 32'(valid), 32'(0));
      for (int rep = 0; rep < 2; rep++)
        for (int l = 0; l < 4; l++) eval_loop(l, int'(vt[v].cnt[l]), rep, 1'b1);
      finish_run($sformatf("vec%0d", v), vt[v].resp, 1'b0, vt[v].resp_sat, vt[v].ovf_sat, 1'b0);
    end

    // Back-to-back: restart from VALID; a stale accumulator would flip bit 0.
    do_start();
    chk("b2b.valid_drop", 32'(valid), 32'(0));
    chk("b2b.resp_clear", 32'(resp), 32'(0));
    eval_loop(0, 3, 0, 1'b1); eval_loop(1, 5, 0, 1'b1);
    eval_loop(2, 9, 0, 1'b1); eval_loop(3, 2, 0, 1'b1);
    finish_run("b2b", 2'b10, 1'b0, 2'b10, 1'b0, 1'b0);

    // Disabled edges not counted; store to an out-of-range index ignored.
    do_start();
    eval_loop(0, 3, 0, 1'b1);
    eval_loop(1, 2, 3, 1'b1);
    store_sel(5);
    finish_run("edge_cases", 2'b01, 1'b0, 2'b01, 1'b0, 1'b0);

    // reset_puf coinciding with a counted edge leaves the counter at 0.
    do_start();
    sel = 3'd0; en = 1'b1;
    ro_edge(0); ro_edge(0);
    chk("cnt_pre_reset", 32'(dut.r_cnt), 32'(2));
    ro[0] = 1'b1;
    tick(1);
    reset_puf = 1'b1;
    tick(2);
    reset_puf = 1'b0;
    tick(3);
    ro[0] = 1'b0;
    tick(4);
    en = 1'b0;
    chk("cnt_reset_edge", 32'(dut.r_cnt), 32'(0));

    // Counter saturation on the 4-bit instance.
    do_start();
    eval_loop(0, 20, 0, 1'b0);
    chk("sat.cnt", 32'(dut_sat.r_cnt), 32'(15));
    chk("sat.cnt_wide", 32'(dut.r_cnt), 32'(20));
    chk("sat.ovf_set", 32'(ovf_s), 32'(1));
    chk("sat.ovf_wide", 32'(ovf), 32'(0));
    store_sel(0);
    tick(3);
    chk("sat.ovf_sticky", 32'(ovf_s), 32'(1));
    finish_run("sat", 2'b01, 1'b0, 2'b01, 1'b1, 1'b0);
    do_start();
    chk("sat.ovf_cleared", 32'(ovf_s), 32'(0));

    // start and done together: start wins, run stays in COLLECT.
    eval_loop(0, 4, 0, 1'b1);
    start = 1'b1; done = 1'b1;
    tick(1);
    start = 1'b0; done = 1'b0;
    tick(3);
    chk("start_done.valid", 32'(valid), 32'(0));
    chk("start_done.state", 32'(dut.r_state), 32'(COLLECT));
    // store and done together: stored count participates in the compare.
    eval_loop(0, 5, 0, 1'b0);
    finish_run("store_done", 2'b01, 1'b0, 2'b01, 1'b0, 1'b1);

    // Reset mid-run after stores.
    do_start();
    eval_loop(0, 20, 0, 1'b1);
    eval_loop(1, 3, 0, 1'b1);
    chk("midrst.pre_ovf", 32'(ovf_s), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst.resp", 32'(resp), 32'(0));
    chk("midrst.valid", 32'(valid), 32'(0));
    chk("midrst.ovf", 32'(ovf), 32'(0));
    chk("midrst.sat_ovf", 32'(ovf_s), 32'(0));
    chk("midrst.state", 32'(dut.r_state), 32'(IDLE));
    tick(2);
    rst_n = 1'b1;
    tick(2);
    done = 1'b1; tick(1); done = 1'b0; tick(3);
    chk("midrst.no_valid", 32'(valid), 32'(0));

    // Randomized runs against per-loop edge totals.
    for (int r = 0; r < 6; r++) begin
      do_start();
      reps = int'($urandom_range(1, 3));
      for (int l = 0; l < 4; l++) begin
        acc[l]  = 0;
        accs[l] = 0;
      end
      sov = 1'b0;
      for (int rep = 0; rep < reps; rep++) begin
        for (int l = 0; l < 4; l++) begin
          c = int'($urandom_range(0, 20));
          eval_loop(l, c, int'($urandom_range(0, 1)), 1'b1);
          acc[l]  += c;
          accs[l] += (c > 15) ? 15 : c;
          if (c > 15) sov = 1'b1;
          if ($urandom_range(0, 3) == 0) store_sel(int'($urandom_range(4, 7)));
        end
      end
      er  = {acc[2] > acc[3], acc[0] > acc[1]};
      esr = {accs[2] > accs[3], accs[0] > accs[1]};
      finish_run($sformatf("rand%0d", r), er, 1'b0, esr, sov, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
